// File: rtl/mvp_matrix_fifo.sv
// rtl/mvp_matrix_fifo.sv - MVP matrix queue: 16-element row-major assembly, DEPTH-deep matrix FIFO
// Optional sticky underflow/overflow outputs when MVP_MATRIX_FIFO_ERR_FLAGS_EN is defined.
module mvp_matrix_fifo #(
    parameter int DATAWIDTH = 24,
    parameter int DEPTH     = 4,
    parameter int CNTWIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  i_clear,
    input  logic                                  i_elem_valid,
    input  logic signed [DATAWIDTH-1:0]           i_elem,
    output logic                                  o_elem_ready,
    input  logic                                  i_read_en,
    output logic signed [3:0][3:0][DATAWIDTH-1:0] o_mvp_matrix,
    output logic                                  o_mvp_dv,
    output logic                                  o_empty,
    output logic                                  o_full,
    output logic [CNTWIDTH-1:0]                   o_count
`ifdef MVP_MATRIX_FIFO_ERR_FLAGS_EN
    ,
    output logic                                  o_underflow,
    output logic                                  o_overflow
`endif
);

    localparam int PTRW = $clog2(DEPTH);

    logic [PTRW-1:0]      wr_ptr;
    logic [PTRW-1:0]      rd_ptr;
    logic [3:0]           elem_idx;
    logic [CNTWIDTH-1:0]  count;
    logic [DATAWIDTH-1:0] mem [DEPTH][16];
    logic [3:0][3:0][DATAWIDTH-1:0] rd_matrix;

    logic accept;
    logic commit;
    logic pop;

    assign o_count      = count;
    assign o_empty      = (count == '0);
    assign o_full       = (count == CNTWIDTH'(DEPTH));
    assign o_elem_ready = rstn && !o_full;

    assign accept = i_elem_valid && o_elem_ready;
    assign commit = accept && (elem_idx == 4'd15);
    assign pop    = i_read_en && !o_empty;

    always_comb begin
        rd_matrix = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                rd_matrix[r][c] = mem[rd_ptr][4'(r * 4 + c)];
            end
        end
    end

    // Partial matrices land straight in the uncommitted slot; count gates visibility.
    always_ff @(posedge clk) begin
        if (rstn && !i_clear && accept) begin
            mem[wr_ptr][elem_idx] <= i_elem;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            elem_idx     <= '0;
            count        <= '0;
            o_mvp_dv     <= 1'b0;
            o_mvp_matrix <= '0;
        end else if (i_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            elem_idx <= '0;
            count    <= '0;
            o_mvp_dv <= 1'b0;
        end else begin
            if (accept) begin
                elem_idx <= elem_idx + 4'd1;
            end
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            o_mvp_dv <= pop;
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                o_mvp_matrix <= rd_matrix;
            end
            case ({commit, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef MVP_MATRIX_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!rstn || i_clear) begin
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            if (i_read_en && o_empty) begin
                o_underflow <= 1'b1;
            end
            if (i_elem_valid && !o_elem_ready) begin
                o_overflow <= 1'b1;
            end
        end
    end
`endif

endmodule
